booth_seq_multiplier: RTL
=========================

# booth_seq_multiplier

Parametrised sequential radix-4 Booth multiplier with a start/valid handshake and per-operand signedness, so it covers the signed, unsigned and mixed-sign multiply variants. It consumes one recoded digit pair per cycle and returns the full double-width product. It sits beside the divider in the multiply/divide unit. The unit's top-level sequencer drives `start` and picks the high or low half of `product`.

## Interface
Parameters:
- `WIDTH`, 32: operand width. Must be even and ≥ 4; elaboration fails otherwise.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when `ready`=1.
- `a_signed`  in  1  1 = `multiplicand` is two's complement; 0 = unsigned.
- `b_signed`  in  1  1 = `multiplier` is two's complement; 0 = unsigned.
- `multiplicand`  in  WIDTH  operand A; sampled together with `start`.
- `multiplier`  in  WIDTH  operand B; sampled together with `start`.
- `flush`  in  1  synchronous abort; dominates `start`.
- `ready`  out  1  block can accept `start` this cycle.
- `busy`  out  1  iteration in progress.
- `valid`  out  1  one-cycle pulse; `product` is new this cycle.
- `product`  out  2*WIDTH  exact product A×B in the selected signedness.

## Operation
- Operand extension on accept:
  - A and B are extended to E = WIDTH+2 bits.
  - Sign extension when the matching `*_signed` bit is 1; zero extension otherwise.
- Iteration count: N = E/2 = WIDTH/2+1 radix-4 iterations.
- Booth recoding:
  - Iteration i examines B_ext bits {2i+1, 2i, 2i−1}, with bit −1 = 0.
  - Selected partial product is one of {0, ±A, ±2A}.
  - Negation uses bitwise inversion plus a carry-in. No separate negate register.
- Accumulator: E+1 bits high part plus a shifting low part. Each iteration adds the partial product to the high part, then arithmetic-shifts the accumulator right by 2.
- Internal representation is free: redundant carry-save or non-redundant. It must meet the latency below, with any final carry-propagate add done inside the N+1 cycle budget.
- `product` = low 2*WIDTH bits of the final accumulator. This is exact for every signedness combination; no overflow is possible.
- A 2-bit state register `state` holds one of three states:
  - IDLE: `ready`=1, `busy`=0. `start` & !`flush` → ITER; operands and signedness are latched and the iteration counter is cleared.
  - ITER: `ready`=0, `busy`=1. Counter increments each cycle. Counter = N−1 → DONE.
  - DONE: `valid`=1, `ready`=1, `busy`=0, and `product` is updated this cycle. `start` → ITER (back-to-back); otherwise → IDLE.
- `start` while `busy` is ignored; operand inputs are don't-care outside the accept cycle.
- `flush` in any state → IDLE next edge:
  - no `valid` is produced;
  - `product` keeps its previous value;
  - `start` in the same cycle is dropped.
- `product` holds its value from one `valid` until the next; it is stable in IDLE.

## Timing
- Reset values (`rst_n`=0, immediate): state IDLE, `ready`=1, `busy`=0, `valid`=0, `product`=0, counter=0.
- Reset asserted mid-ITER aborts without `valid`. The first accept after release behaves as from cold.
- Latency: `start` accepted at edge k → `busy` high in cycles k..k+N−1 → `valid` high for exactly the one cycle after edge k+N. That is N+1 cycles from request to result; WIDTH=32 gives 18.
- Throughput: one result per N+1 cycles with back-to-back `start` in DONE. No idle bubble.
- All outputs are registered or decoded from registered state only; no input-to-output combinational path.

## Test plan
- WIDTH=32, unsigned, 0xFFFFFFFF × 0xFFFFFFFF → `product`=0xFFFFFFFE00000001; `valid` exactly 18 cycles after `start`, single-cycle.
- WIDTH=32, both signed:
  - 0xFFFFFFFF × 0xFFFFFFFF → 0x0000000000000001;
  - 0x80000000 × 0x80000000 → 0x4000000000000000.
- WIDTH=32, mixed signedness:
  - A signed 0xFFFFFFFF × B unsigned 0xFFFFFFFF → 0xFFFFFFFF00000001;
  - A unsigned 7 × B signed 0xFFFFFFFE → 0xFFFFFFFFFFFFFFF2.
- Back-to-back: `start` held high through DONE with 3 × 5 then 0x10000 × 0x10000 (unsigned) → `valid` pulses 18 cycles apart with 15 then 0x100000000; `start` during ITER ignored.
- `flush` in iteration 5, and `rst_n` pulsed low mid-ITER → no `valid`, `ready` next cycle, `product` unchanged (after reset: 0); a following 2×3 yields 6.
- WIDTH=8, exhaustive over all 65536 operand pairs × 4 signedness modes vs reference model. Latency 6, `product` exact.

Source files
------------

// File: rtl/booth_seq_multiplier_if.sv
// Handshake and data bundle between the multiply/divide sequencer and the
// sequential Booth multiplier. The sequencer is the master.
interface booth_seq_multiplier_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic                   a_signed;
    logic                   b_signed;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   flush;
    logic                   ready;
    logic                   busy;
    logic                   valid;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, a_signed, b_signed, multiplicand, multiplier, flush,
        input  ready, busy, valid, product
    );

    modport slave (
        input  start, a_signed, b_signed, multiplicand, multiplier, flush,
        output ready, busy, valid, product
    );
endinterface

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-4 Booth multiplier with per-operand signedness.
// Operands are extended by two bits so one datapath covers signed, unsigned
// and mixed multiplies; one Booth digit is retired per cycle and the full
// double-width product is returned N+1 cycles after the request.
// WIDTH must match the WIDTH of the connected interface instance.
module booth_seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    booth_seq_multiplier_if.slave bus
);

    localparam int E  = WIDTH + 2;      // extended operand width
    localparam int N  = E / 2;          // radix-4 iterations
    localparam int CW = $clog2(N + 1);  // iteration counter width
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
            $error("booth_seq_multiplier: WIDTH must be even and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;
    logic               w_step;
    logic               w_last;
    logic               w_ready;
    logic               w_busy;
    logic               w_valid;

    logic [CW-1:0]      r_count;
    logic [E-1:0]       r_a_ext;     // extended multiplicand
    logic [E:0]         r_hi;        // running high part of the accumulator
    logic [E-1:0]       r_lo;        // shifts out B, shifts in product bits
    logic               r_prev;      // Booth bit i-1 (0 before the first digit)
    logic [2*WIDTH-1:0] r_product;

    logic [E-1:0]       w_a_ext;
    logic [E-1:0]       w_b_ext;
    logic [2:0]         w_triplet;
    logic               w_neg;
    logic               w_two;
    logic               w_zero;
    logic [E:0]         w_pp_mag;
    logic [E:0]         w_addend;
    logic [E:0]         w_sum;
    logic [E:0]         w_hi_next;
    logic [E-1:0]       w_lo_next;
    logic [2*WIDTH-1:0] w_product_next;

    // Operand extension: two extra bits make every signedness mix a plain
    // two's complement multiply whose low 2*WIDTH bits are exact.
    assign w_a_ext = {{2{bus.a_signed & bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
    assign w_b_ext = {{2{bus.b_signed & bus.multiplier[WIDTH-1]}}, bus.multiplier};

    // State register; an asserted reset abandons any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake decode; flush overrides everything, including
    // a start presented in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        w_ready      = 1'b0;
        w_busy       = 1'b0;
        w_valid      = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (bus.start) begin
                    w_state_next = ITER;
                    w_accept     = 1'b1;
                end
            end
            ITER: begin
                w_busy = 1'b1;
                w_step = 1'b1;
                if (r_count == LAST) begin
                    w_last       = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_valid = 1'b1;
                w_ready = 1'b1;
                if (bus.start) begin
                    w_state_next = ITER;
                    w_accept     = 1'b1;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (bus.flush) begin
            w_state_next = IDLE;
            w_accept     = 1'b0;
            w_step       = 1'b0;
            w_last       = 1'b0;
        end
    end

    // Radix-4 Booth recoding of {b[2i+1], b[2i], b[2i-1]} into 0, +-A, +-2A.
    assign w_triplet = {r_lo[1], r_lo[0], r_prev};

    always_comb begin
        w_neg  = 1'b0;
        w_two  = 1'b0;
        w_zero = 1'b0;
        case (w_triplet)
            3'b000, 3'b111: w_zero = 1'b1;
            3'b001, 3'b010: w_neg  = 1'b0;
            3'b011:         w_two  = 1'b1;
            3'b100: begin
                w_two = 1'b1;
                w_neg = 1'b1;
            end
            default:        w_neg  = 1'b1;  // 101, 110: -A
        endcase
    end

    // Negative digits invert the magnitude and add one through the carry-in,
    // so no negated copy of A is ever stored.
    assign w_pp_mag  = w_zero ? '0 : (w_two ? {r_a_ext, 1'b0} : {r_a_ext[E-1], r_a_ext});
    assign w_addend  = w_neg ? ~w_pp_mag : w_pp_mag;
    assign w_sum     = r_hi + w_addend + {{E{1'b0}}, w_neg};

    // Arithmetic shift right by two across the high and low parts.
    assign w_hi_next = {{2{w_sum[E]}}, w_sum[E:2]};
    assign w_lo_next = {w_sum[1:0], r_lo[E-1:2]};

    // After the final shift the low E bits sit in r_lo and the rest in r_hi.
    assign w_product_next = {w_hi_next[WIDTH-3:0], w_lo_next};

    // Accumulator and iteration counter: load on accept, step while iterating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_a_ext <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_prev  <= 1'b0;
        end else if (w_accept) begin
            r_count <= '0;
            r_a_ext <= w_a_ext;
            r_hi    <= '0;
            r_lo    <= w_b_ext;
            r_prev  <= 1'b0;
        end else if (w_step) begin
            r_count <= r_count + CW'(1);
            r_hi    <= w_hi_next;
            r_lo    <= w_lo_next;
            r_prev  <= r_lo[1];
        end
    end

    // Result register: written only on the last iteration, so it holds its
    // value through IDLE, flushes and new multiplies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_product <= '0;
        end else if (w_last) begin
            r_product <= w_product_next;
        end
    end

    assign bus.ready   = w_ready;
    assign bus.busy    = w_busy;
    assign bus.valid   = w_valid;
    assign bus.product = r_product;

endmodule
